// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the program
// counter and the IF/ID pipeline register, drives the instruction-memory
// address and selects the next PC from PC+4, the ID-resolved branch target
// or the jump target of the instruction currently in ID.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_write            0 freezes the PC (hazard unit stall)
//   ifid_write          0 freezes the IF/ID register
//   pc_src              taken branch resolved in ID
//   branch_target       branch target computed in ID
//   jump                instruction in ID is a j
//   imem_addr           fetch address (alias of pc)
//   imem_rdata          combinational instruction word for imem_addr
//   imem_ready          imem_rdata valid this cycle
//   pc                  current PC
//   ifid_instr          registered instruction to ID
//   ifid_pc4            registered PC+4 of ifid_instr
//   ifid_valid          1 = real fetched instruction, 0 = bubble
//   fetch_count         instructions accepted into IF/ID (wrapping)
//   stall_count         cycles with pc_write=0 (wrapping)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        ifid_write,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   input  logic        jump,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   logic [31:0] pc_r;
   logic [31:0] ifid_instr_r;
   logic [31:0] ifid_pc4_r;
   logic        ifid_valid_r;
   logic [31:0] fetch_count_r;
   logic [31:0] stall_count_r;

   logic [31:0] pc_nxt_s;
   logic [31:0] ifid_instr_nxt_s;
   logic [31:0] ifid_pc4_nxt_s;
   logic        ifid_valid_nxt_s;
   logic [31:0] fetch_count_nxt_s;
   logic [31:0] stall_count_nxt_s;

   logic [31:0] pc4_s;
   logic [31:0] jump_target_s;

   // Sequential address and jump target formed from the instruction in ID
   always_comb begin
      pc4_s         = pc_r + 32'd4;
      jump_target_s = {ifid_pc4_r[31:28], ifid_instr_r[25:0], 2'b00};
   end

   // Next-state selection: stall > redirect > fetch > memory wait > hold
   always_comb begin
      pc_nxt_s          = pc_r;
      ifid_instr_nxt_s  = ifid_instr_r;
      ifid_pc4_nxt_s    = ifid_pc4_r;
      ifid_valid_nxt_s  = ifid_valid_r;
      fetch_count_nxt_s = fetch_count_r;
      stall_count_nxt_s = stall_count_r;

      if (!pc_write) begin
         // Redirects are ignored here: the hazard unit masks a stalled branch
         stall_count_nxt_s = stall_count_r + 32'd1;
         if (ifid_write) begin
            ifid_instr_nxt_s = BUBBLE;
            ifid_pc4_nxt_s   = 32'h0000_0000;
            ifid_valid_nxt_s = 1'b0;
         end else begin
            ifid_valid_nxt_s = ifid_valid_r;
         end
      end else if (jump || pc_src) begin
         // The wrong-path word fetched this cycle is squashed into a bubble
         pc_nxt_s         = jump ? jump_target_s : branch_target;
         ifid_instr_nxt_s = BUBBLE;
         ifid_pc4_nxt_s   = 32'h0000_0000;
         ifid_valid_nxt_s = 1'b0;
      end else if (imem_ready) begin
         if (ifid_write) begin
            pc_nxt_s          = pc4_s;
            ifid_instr_nxt_s  = imem_rdata;
            ifid_pc4_nxt_s    = pc4_s;
            ifid_valid_nxt_s  = 1'b1;
            fetch_count_nxt_s = fetch_count_r + 32'd1;
         end else begin
            // IF/ID cannot accept: keep the PC so the word is refetched
            pc_nxt_s = pc_r;
         end
      end else begin
         if (ifid_write) begin
            ifid_instr_nxt_s = BUBBLE;
            ifid_pc4_nxt_s   = 32'h0000_0000;
            ifid_valid_nxt_s = 1'b0;
         end else begin
            ifid_valid_nxt_s = ifid_valid_r;
         end
      end
   end

   // PC, IF/ID register and event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC;
         ifid_instr_r  <= BUBBLE;
         ifid_pc4_r    <= 32'h0000_0000;
         ifid_valid_r  <= 1'b0;
         fetch_count_r <= 32'h0000_0000;
         stall_count_r <= 32'h0000_0000;
      end else begin
         pc_r          <= pc_nxt_s;
         ifid_instr_r  <= ifid_instr_nxt_s;
         ifid_pc4_r    <= ifid_pc4_nxt_s;
         ifid_valid_r  <= ifid_valid_nxt_s;
         fetch_count_r <= fetch_count_nxt_s;
         stall_count_r <= stall_count_nxt_s;
      end
   end

   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign ifid_instr  = ifid_instr_r;
   assign ifid_pc4    = ifid_pc4_r;
   assign ifid_valid  = ifid_valid_r;
   assign fetch_count = fetch_count_r;
   assign stall_count = stall_count_r;

endmodule
